// File: rtl/yousei_pkg.sv
// Shared definitions for the kernel message path: field widths, opcodes,
// the display FSM encoding and the queued message record.
package yousei_pkg;

  localparam int MSG_W   = 5;
  localparam int PID_W   = 5;
  localparam int ENTRY_W = MSG_W + PID_W;

  localparam logic [5:0] EMIT_MSG    = 6'b011010;
  localparam logic [5:0] ROUND_ROBIN = 6'b011011;
  localparam logic [5:0] SET_PID     = 6'b011100;
  localparam logic [5:0] CREATE_FILE = 6'b011101;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  typedef struct packed {
    logic [PID_W-1:0] pid;
    logic [MSG_W-1:0] msg;
  } msg_entry_t;

  // Width of the hold counter: enough to hold HOLD_CYCLES-1, never zero.
  function automatic int hold_width(input int hold_cycles);
    return ($clog2(hold_cycles) < 1) ? 1 : $clog2(hold_cycles);
  endfunction

endpackage

// File: rtl/msg_display_queue_if.sv
// Bundle between the environment-variables block (producer), the user
// acknowledge input and the display drivers.
interface msg_display_queue_if #(
  parameter int DEPTH = 4
);
  import yousei_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: MSG_Sign is a valid-only strobe, one message per high cycle,
  // with no ready; the queue always takes it or drops it and flags Overflow.
  logic             MSG_Sign;
  logic [MSG_W-1:0] MSG_OUT;
  logic [PID_W-1:0] PID_in;
  logic             Ack;

  logic [MSG_W-1:0] Disp_Msg;
  logic [PID_W-1:0] Disp_PID;
  logic             Disp_Valid;
  logic             Queue_Full;
  logic             Overflow;
  logic [CW-1:0]    Count;
  state_t           dbg_state;

  modport master (
    output MSG_Sign, MSG_OUT, PID_in, Ack,
    input  Disp_Msg, Disp_PID, Disp_Valid, Queue_Full, Overflow, Count, dbg_state
  );

  modport slave (
    input  MSG_Sign, MSG_OUT, PID_in, Ack,
    output Disp_Msg, Disp_PID, Disp_Valid, Queue_Full, Overflow, Count, dbg_state
  );

endinterface

// File: rtl/msg_fifo.sv
// Synchronous FIFO with separate occupancy counter; a push while full is
// still accepted when a pop happens on the same edge.
module msg_fifo
  import yousei_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_data,
  output logic [W-1:0]           o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_accept,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rd_ptr];
  assign w_pop    = i_pop && !o_empty;
  assign w_push   = i_push && (!o_full || w_pop);
  assign o_accept = w_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/msg_display_queue.sv
// Queues kernel messages tagged with the current PID and shows them one at a
// time for HOLD_CYCLES clocks, or until the user acknowledges.
module msg_display_queue
  import yousei_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                reset,
  msg_display_queue_if.slave  bus
);

  localparam int            HW        = hold_width(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam int            CW        = $clog2(DEPTH) + 1;

  state_t           r_state;
  state_t           w_next_state;
  logic [HW-1:0]    r_hold;
  logic             r_overflow;
  msg_entry_t       r_disp;

  logic             w_advance;
  logic             w_pop;
  logic             w_disp_valid;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic [CW-1:0]    w_count;
  msg_entry_t       w_head;

  msg_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .i_push   (bus.MSG_Sign),
    .i_pop    (w_pop),
    .i_data   ({bus.PID_in, bus.MSG_OUT}),
    .o_data   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_accept (w_accept),
    .o_count  (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_next_state = SHOW;
      SHOW:    if (w_advance && w_empty) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Ack and an expired hold counter collapse into one advance.
  always_comb begin
    w_advance    = 1'b0;
    w_pop        = 1'b0;
    w_disp_valid = 1'b0;
    case (r_state)
      IDLE: w_pop = !w_empty;
      SHOW: begin
        w_disp_valid = 1'b1;
        w_advance    = (r_hold == '0) || bus.Ack;
        w_pop        = w_advance && !w_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold     <= '0;
      r_disp     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_hold <= HOLD_LOAD;
        r_disp <= w_head;
      end else if (r_state == SHOW && r_hold != '0) begin
        r_hold <= r_hold - 1'b1;
      end
      if (bus.MSG_Sign && !w_accept) r_overflow <= 1'b1;
    end
  end

  assign bus.Disp_Msg   = r_disp.msg;
  assign bus.Disp_PID   = r_disp.pid;
  assign bus.Disp_Valid = w_disp_valid;
  assign bus.Queue_Full = w_full;
  assign bus.Overflow   = r_overflow;
  assign bus.Count      = w_count;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_msg_display_queue.sv
// Directed bench for msg_display_queue with DEPTH=4, HOLD_CYCLES=4.
module tb_msg_display_queue;
  import yousei_pkg::*;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  msg_display_queue_if #(.DEPTH(DEPTH)) bus ();

  msg_display_queue #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       sign;
    logic [4:0] msg;
    logic [4:0] pid;
    logic       ack;
    logic [15:0] exp_out;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  // {valid, msg, pid, count, full, overflow}
  function automatic logic [15:0] pk(input logic v, input logic [4:0] m,
                                     input logic [4:0] p, input logic [2:0] c,
                                     input logic f, input logic o);
    return {v, m, p, c, f, o};
  endfunction

  function automatic logic [15:0] dut_out();
    return {bus.Disp_Valid, bus.Disp_Msg, bus.Disp_PID, bus.Count,
            bus.Queue_Full, bus.Overflow};
  endfunction

  task automatic add(input logic s, input logic [4:0] m, input logic [4:0] p,
                     input logic a, input logic [15:0] e);
    vec_t v;
    v.sign = s; v.msg = m; v.pid = p; v.ack = a; v.exp_out = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got v=%b msg=%h pid=%h cnt=%0d full=%b ovf=%b, expected v=%b msg=%h pid=%h cnt=%0d full=%b ovf=%b",
               name, act[15], act[14:10], act[9:5], act[4:2], act[1], act[0],
               exp[15], exp[14:10], exp[9:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Drive inputs mid-cycle, then look at outputs just after the next rising edge.
  task automatic step(input logic s, input logic [4:0] m, input logic [4:0] p, input logic a);
    @(negedge clk);
    bus.MSG_Sign = s;
    bus.MSG_OUT  = m;
    bus.PID_in   = p;
    bus.Ack      = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single message, hold and drop
    add(1, 5'd3, 5'd2, 0, pk(0, 5'd0, 5'd0, 3'd1, 0, 0));
    add(0, 5'd0, 5'd0, 0, pk(1, 5'd3, 5'd2, 3'd0, 0, 0));
    for (int i = 0; i < 3; i++) add(0, 5'd0, 5'd0, 0, pk(1, 5'd3, 5'd2, 3'd0, 0, 0));
    add(0, 5'd0, 5'd0, 0, pk(0, 5'd3, 5'd2, 3'd0, 0, 0));
    // Burst of three, shown back-to-back
    add(1, 5'd1, 5'd1, 0, pk(0, 5'd3, 5'd2, 3'd1, 0, 0));
    add(1, 5'd2, 5'd1, 0, pk(1, 5'd1, 5'd1, 3'd1, 0, 0));
    add(1, 5'd3, 5'd1, 0, pk(1, 5'd1, 5'd1, 3'd2, 0, 0));
    for (int i = 0; i < 2; i++) add(0, 5'd0, 5'd0, 0, pk(1, 5'd1, 5'd1, 3'd2, 0, 0));
    for (int i = 0; i < 4; i++) add(0, 5'd0, 5'd0, 0, pk(1, 5'd2, 5'd1, 3'd1, 0, 0));
    for (int i = 0; i < 4; i++) add(0, 5'd0, 5'd0, 0, pk(1, 5'd3, 5'd1, 3'd0, 0, 0));
    add(0, 5'd0, 5'd0, 0, pk(0, 5'd3, 5'd1, 3'd0, 0, 0));
    // Fill: push 6 lands on the pop edge, push 7 is dropped
    add(1, 5'd1, 5'd31, 0, pk(0, 5'd3, 5'd1, 3'd1, 0, 0));
    add(1, 5'd2, 5'd31, 0, pk(1, 5'd1, 5'd31, 3'd1, 0, 0));
    add(1, 5'd3, 5'd31, 0, pk(1, 5'd1, 5'd31, 3'd2, 0, 0));
    add(1, 5'd4, 5'd31, 0, pk(1, 5'd1, 5'd31, 3'd3, 0, 0));
    add(1, 5'd5, 5'd31, 0, pk(1, 5'd1, 5'd31, 3'd4, 1, 0));
    add(1, 5'd6, 5'd31, 0, pk(1, 5'd2, 5'd31, 3'd4, 1, 0));
    add(1, 5'd7, 5'd31, 0, pk(1, 5'd2, 5'd31, 3'd4, 1, 1));
    // Ack skips, including Ack coinciding with hold expiry
    add(0, 5'd0, 5'd0, 1, pk(1, 5'd3, 5'd31, 3'd3, 0, 1));
    add(0, 5'd0, 5'd0, 1, pk(1, 5'd4, 5'd31, 3'd2, 0, 1));
    for (int i = 0; i < 3; i++) add(0, 5'd0, 5'd0, 0, pk(1, 5'd4, 5'd31, 3'd2, 0, 1));
    add(0, 5'd0, 5'd0, 1, pk(1, 5'd5, 5'd31, 3'd1, 0, 1));
    add(0, 5'd0, 5'd0, 0, pk(1, 5'd5, 5'd31, 3'd1, 0, 1));
    add(0, 5'd0, 5'd0, 1, pk(1, 5'd6, 5'd31, 3'd0, 0, 1));
    add(0, 5'd0, 5'd0, 1, pk(0, 5'd6, 5'd31, 3'd0, 0, 1));
    add(0, 5'd0, 5'd0, 1, pk(0, 5'd6, 5'd31, 3'd0, 0, 1));

    bus.MSG_Sign = 1'b0;
    bus.MSG_OUT  = '0;
    bus.PID_in   = '0;
    bus.Ack      = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_values", dut_out(), 16'h0000);

    for (int i = 0; i < 3; i++) begin
      step(0, 5'd0, 5'd0, 1);
      check($sformatf("ack_idle_%0d", i), dut_out(), 16'h0000);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].sign, tbl[i].msg, tbl[i].pid, tbl[i].ack);
      exp_q.push_back(tbl[i].exp_out);
      check($sformatf("vec_%0d", i), dut_out(), exp_q.pop_front());
    end

    // Asynchronous reset while showing with two queued
    step(1, 5'd9, 5'd1, 0);
    check("pre_reset_0", dut_out(), pk(0, 5'd6, 5'd31, 3'd1, 0, 1));
    step(1, 5'd10, 5'd1, 0);
    check("pre_reset_1", dut_out(), pk(1, 5'd9, 5'd1, 3'd1, 0, 1));
    step(1, 5'd11, 5'd1, 0);
    check("pre_reset_2", dut_out(), pk(1, 5'd9, 5'd1, 3'd2, 0, 1));
    bus.MSG_Sign = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", dut_out(), 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    step(1, 5'd12, 5'd3, 0);
    check("post_reset_push", dut_out(), pk(0, 5'd0, 5'd0, 3'd1, 0, 0));
    for (int i = 0; i < 4; i++) begin
      step(0, 5'd0, 5'd0, 0);
      check($sformatf("post_reset_show_%0d", i), dut_out(), pk(1, 5'd12, 5'd3, 3'd0, 0, 0));
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 5'd0, 5'd0, 0);
      check($sformatf("post_reset_idle_%0d", i), dut_out(), pk(0, 5'd12, 5'd3, 3'd0, 0, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
